// File: rtl/cipher_entry_fsm.sv
// Front-end controller for a cipher core: collects key and value chunk by chunk
// from switches and buttons, launches the core and exposes its result on a hex display.
module cipher_entry_fsm #(
  parameter int CHUNK_W    = 16,
  parameter int NUM_CHUNKS = 4,
  localparam int DATA_W    = CHUNK_W * NUM_CHUNKS,
  localparam int SEL_W     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CHUNK_W-1:0] user_input,
  input  logic              send_data,
  input  logic              back_n,
  input  logic              change_state,
  input  logic              encr_go,
  input  logic              mode,
  input  logic [SEL_W-1:0]  select_disp,
  output logic              core_start,
  output logic              core_mode,
  output logic [DATA_W-1:0] core_key,
  output logic [DATA_W-1:0] core_data,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic [CHUNK_W-1:0] disp,
  output logic [SEL_W-1:0]  chunk_idx,
  output logic              key_led,
  output logic              val_led,
  output logic              busy,
  output logic              result_valid
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_KEY_ENTRY = 3'd1;
  localparam logic [2:0] S_KEY_SHOW  = 3'd2;
  localparam logic [2:0] S_VAL_ENTRY = 3'd3;
  localparam logic [2:0] S_VAL_SHOW  = 3'd4;
  localparam logic [2:0] S_ARMED     = 3'd5;
  localparam logic [2:0] S_RUN       = 3'd6;
  localparam logic [2:0] S_RESULT    = 3'd7;

  logic [2:0]         state_q, state_d;
  logic [DATA_W-1:0]  key_q, key_d;
  logic [DATA_W-1:0]  val_q, val_d;
  logic [DATA_W-1:0]  res_q, res_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [CHUNK_W-1:0] disp_q, disp_d;
  logic               start_q, start_d;
  logic               mode_q, mode_d;
  logic [3:0]         btn_hist_q;

  logic [3:0] btn_now;
  logic [3:0] press;
  logic       send_p, back_p, chg_p, go_p;
  logic       last_chunk;

  // Buttons idle high; a press is the 1 -> 0 transition seen against last cycle.
  assign btn_now    = {send_data, back_n, change_state, encr_go};
  assign press      = btn_hist_q & ~btn_now;
  assign send_p     = press[3];
  assign back_p     = press[2];
  assign chg_p      = press[1];
  assign go_p       = press[0];
  assign last_chunk = (int'(idx_q) == NUM_CHUNKS - 1);

  // Chunk 0 occupies the most significant bits of the assembled word.
  function automatic logic [DATA_W-1:0] put_chunk(input logic [DATA_W-1:0] d,
                                                  input logic [SEL_W-1:0]  i,
                                                  input logic [CHUNK_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = d;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (int'(i) == k) r[DATA_W-1-k*CHUNK_W -: CHUNK_W] = v;
    end
    return r;
  endfunction

  // Display select counts from the least significant chunk; out-of-range shows 0.
  function automatic logic [CHUNK_W-1:0] get_chunk(input logic [DATA_W-1:0] d,
                                                   input logic [SEL_W-1:0]  s);
    logic [CHUNK_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (int'(s) == k) r = d[k*CHUNK_W +: CHUNK_W];
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    val_d   = val_q;
    res_d   = res_q;
    idx_d   = idx_q;
    start_d = 1'b0;
    mode_d  = mode_q;
    disp_d  = '0;
    case (state_q)
      S_IDLE: begin
        key_d   = '0;
        val_d   = '0;
        idx_d   = '0;
        state_d = S_KEY_ENTRY;
      end
      S_KEY_ENTRY, S_VAL_ENTRY: begin
        disp_d = user_input;
        if (send_p) begin
          if (state_q == S_KEY_ENTRY) key_d = put_chunk(key_q, idx_q, user_input);
          else                        val_d = put_chunk(val_q, idx_q, user_input);
          if (last_chunk) begin
            idx_d   = '0;
            state_d = (state_q == S_KEY_ENTRY) ? S_KEY_SHOW : S_VAL_SHOW;
          end else begin
            idx_d = idx_q + SEL_W'(1'b1);
          end
        end else if (back_p && idx_q != '0) begin
          idx_d = idx_q - SEL_W'(1'b1);
        end
      end
      S_KEY_SHOW: begin
        disp_d = get_chunk(key_q, select_disp);
        if (chg_p) state_d = S_VAL_ENTRY;
      end
      S_VAL_SHOW: begin
        disp_d = get_chunk(val_q, select_disp);
        if (chg_p) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (go_p) begin
          mode_d  = mode;
          start_d = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (core_done) begin
          res_d   = core_result;
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        disp_d = get_chunk(res_q, select_disp);
        if (go_p) begin
          state_d = S_IDLE;
        end else if (chg_p) begin
          idx_d   = '0;
          state_d = S_VAL_ENTRY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      val_q      <= '0;
      res_q      <= '0;
      idx_q      <= '0;
      disp_q     <= '0;
      start_q    <= 1'b0;
      mode_q     <= 1'b0;
      btn_hist_q <= 4'hF;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      val_q      <= val_d;
      res_q      <= res_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      start_q    <= start_d;
      mode_q     <= mode_d;
      btn_hist_q <= btn_now;
    end
  end

  assign core_start   = start_q;
  assign core_mode    = mode_q;
  assign core_key     = key_q;
  assign core_data    = val_q;
  assign disp         = disp_q;
  assign chunk_idx    = idx_q;
  assign key_led      = (state_q == S_KEY_SHOW);
  assign val_led      = (state_q == S_VAL_SHOW);
  assign busy         = (state_q == S_RUN);
  assign result_valid = (state_q == S_RESULT);

endmodule
